// File: rtl/bridge_pkg.sv
// Shared definitions for the AHB-to-APB bridge command path.
package bridge_pkg;

  localparam int DW_DEF = 32;
  localparam int AW_DEF = 32;

  function automatic int clog2(input int v);
    int r;
    for (r = 0; (1 << r) < v; r++) begin
    end
    return r;
  endfunction

  function automatic int entry_w(input int dw, input int aw);
    return dw + aw + 1;
  endfunction

  // Packed entry layout: {write flag, address, data}
  function automatic int data_ofs();
    return 0;
  endfunction

  function automatic int addr_ofs(input int dw);
    return dw;
  endfunction

  function automatic int wflag_ofs(input int dw, input int aw);
    return dw + aw;
  endfunction

  localparam int EW = entry_w(DW_DEF, AW_DEF);

endpackage

// File: rtl/sync_fifo_mem.sv
// Register-array storage for the command FIFO.
module sync_fifo_mem #(
  parameter int EW    = 65,
  parameter int DEPTH = 8,
  parameter int PW    = 3
) (
  input  logic          clk,
  input  logic          we,
  input  logic [PW-1:0] waddr,
  input  logic [EW-1:0] wdata,
  input  logic [PW-1:0] raddr,
  output logic [EW-1:0] rdata
);

  logic [EW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ahb_apb_cmd_fifo.sv
// First-word-fall-through command FIFO between AHB capture and APB FSM.
module ahb_apb_cmd_fifo
  import bridge_pkg::*;
#(
  parameter int DW         = 32,
  parameter int AW         = 32,
  parameter int DEPTH      = 8,
  parameter int AF_LEVEL   = 6,
  parameter int WRITE_ONLY = 1,
  localparam int CW        = clog2(DEPTH + 1)
) (
  input  logic          Hclk,
  input  logic          Hresetn,
  input  logic [AW-1:0] Haddr_temp,
  input  logic [DW-1:0] Hwdata_temp,
  input  logic          valid,
  input  logic          Hwrite_temp,
  input  logic          Pready,
  input  logic          Pint,
  input  logic          flush,
  output logic [DW-1:0] data_temp,
  output logic [AW:0]   addr_temp,
  output logic          transfer,
  output logic          full,
  output logic          almost_full,
  output logic [CW-1:0] count,
  output logic          overflow
);

  localparam int PW   = clog2(DEPTH);
  localparam int NEW  = entry_w(DW, AW);
  localparam int AOFS = addr_ofs(DW);
  localparam int WOFS = wflag_ofs(DW, AW);
  localparam logic [CW-1:0] ONE   = CW'(1);
  localparam logic [CW-1:0] C_MAX = CW'(DEPTH);
  localparam logic [CW-1:0] C_AF  = CW'(AF_LEVEL);
  localparam logic [PW-1:0] P_ONE = PW'(1);

  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [NEW-1:0] head;
  logic           push_req;
  logic           push;
  logic           pop;

  assign push_req = valid && (Hwrite_temp || (WRITE_ONLY == 0));
  assign push     = push_req && !full;
  assign pop      = transfer && Pready && Pint;

  assign transfer    = (count != '0);
  assign full        = (count == C_MAX);
  assign almost_full = (count >= C_AF);

  sync_fifo_mem #(
    .EW    (NEW),
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_mem (
    .clk   (Hclk),
    .we    (push && Hresetn && !flush),
    .waddr (wr_ptr),
    .wdata ({Hwrite_temp, Haddr_temp, Hwdata_temp}),
    .raddr (rd_ptr),
    .rdata (head)
  );

  always_ff @(posedge Hclk) begin
    if (!Hresetn || flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + P_ONE;
      if (pop)  rd_ptr <= rd_ptr + P_ONE;
      if (push && !pop)      count <= count + ONE;
      else if (pop && !push) count <= count - ONE;
      if (push_req && full) overflow <= 1'b1;
    end
  end

  // Empty FIFO presents zeros rather than stale storage
  assign data_temp = transfer ? head[AOFS-1:0] : '0;
  assign addr_temp = transfer ? {head[WOFS], head[WOFS-1:AOFS]} : '0;

endmodule
